// File: rtl/multibyte_add_seq.sv
`default_nettype none
// =============================================================================
// Module   : multibyte_add_seq
// Purpose  : N-byte add/subtract sequenced one byte per clock through an
//            external 8-bit combinational ripple-carry adder.
// Revision : 1.0 - initial release
// =============================================================================
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_s,
    input  logic                  add_cout
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       opa_q, opa_d;
    logic [W-1:0]       opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-9:0]       acc_q, acc_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [IDX_W+2:0]   w_ofs;
    logic               w_run;

    assign w_ofs = {idx_q, 3'b000};
    assign w_run = (state_q == S_RUN);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B once here, inject the +1 as carry-in.
                    state_d = S_RUN;
                    opa_d   = a;
                    opb_d   = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d = add_cout;
                if (idx_q == C_LAST_IDX) begin
                    sum_d   = {add_s, acc_q};
                    cout_d  = add_cout;
                    ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (add_s[7] != opa_q[W-1]);
                    state_d = S_DONE;
                end else begin
                    acc_d[w_ofs +: 8] = add_s;
                    idx_d             = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy    = w_run;
    assign done    = (state_q == S_DONE);
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign add_a   = w_run ? opa_q[w_ofs +: 8] : 8'h00;
    assign add_b   = w_run ? opb_q[w_ofs +: 8] : 8'h00;
    assign add_cin = w_run & carry_q;

endmodule
`default_nettype wire

// File: tb/tb_multibyte_add_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_multibyte_add_seq
// Purpose  : Self-checking bench for multibyte_add_seq with an arithmetic model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_multibyte_add_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           sub = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, cout, ovf, add_cin, add_cout;
    logic [W-1:0]   sum;
    logic [7:0]     add_a, add_b, add_s;

    int n_pass  = 0;
    int n_total = 0;
    bit mon_en  = 1'b0;

    multibyte_add_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout)
    );

    // The external 8-bit ripple-carry adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: an operation takes NBYTES cycles; results from plain arithmetic.
    bit           m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0;
    logic [W-1:0] m_sum = '0;
    int           m_rem = 0;
    logic [W-1:0] p_a = '0, p_b = '0;
    logic         p_sub = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    longint sa, sb, r;
                    m_busy = 0;
                    m_done = 1;
                    sa = longint'($signed(p_a));
                    sb = longint'($signed(p_b));
                    r  = p_sub ? sa - sb : sa + sb;
                    m_sum  = p_sub ? p_a - p_b : p_a + p_b;
                    m_cout = p_sub ? (p_a >= p_b) : (({1'b0, p_a} + {1'b0, p_b}) >> W) != 0;
                    m_ovf  = (r > 64'sh7FFFFFFF) || (r < -64'sh80000000);
                end
            end else if (start) begin
                m_busy = 1; m_rem = NBYTES; p_a = a; p_b = b; p_sub = sub;
            end
        end
    end

    // Compare process: every cycle, outputs against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [W:0]   opb, lo_sum, mask;
            logic [7:0]   exp_a, exp_b;
            logic         exp_cin;
            int           k;
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("sum",  64'(sum),  64'(m_sum));
            chk("cout", 64'(cout), 64'(m_cout));
            chk("ovf",  64'(ovf),  64'(m_ovf));
            exp_a = 8'h00; exp_b = 8'h00; exp_cin = 1'b0;
            if (m_busy) begin
                k       = NBYTES - m_rem;
                opb     = {1'b0, p_sub ? ~p_b : p_b};
                mask    = (({{W{1'b0}}, 1'b1}) << (8 * k)) - 1'b1;
                lo_sum  = ({1'b0, p_a} & mask) + (opb & mask) + {{W{1'b0}}, p_sub};
                exp_a   = 8'(p_a >> (8 * k));
                exp_b   = 8'(opb >> (8 * k));
                exp_cin = (k == 0) ? p_sub : lo_sum[8 * k];
            end
            chk("add_a",   64'(add_a),   64'(exp_a));
            chk("add_b",   64'(add_b),   64'(exp_b));
            chk("add_cin", 64'(add_cin), 64'(exp_cin));
        end
    end

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
        start = 1'b1; a = ta; b = tb_v; sub = ts;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
    endtask

    task automatic lit(input string name, input logic [W-1:0] es, input logic ec, input logic eo, input int n);
        chk({name, "_sum"},  64'(sum),  64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        chk({name, "_ovf"},  64'(ovf),  64'(eo));
        chk({name, "_lat"},  64'(n),    64'(NBYTES));
    endtask

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int n;
        // Reset held two cycles with start asserted.
        start = 1'b1; a = 32'h1234; b = 32'h1;
        @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum",  64'(sum),  64'd0);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);

        start_op(32'h0000_00FF, 32'h0000_0001, 1'b0); wait_done(n); lit("byte_carry", 32'h0000_0100, 0, 0, n);
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); wait_done(n); lit("wrap",       32'h0000_0000, 1, 0, n);
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); wait_done(n); lit("sovf_add",   32'h8000_0000, 0, 1, n);
        start_op(32'h0000_0005, 32'h0000_0007, 1'b1); wait_done(n); lit("sub_neg",    32'hFFFF_FFFE, 0, 0, n);
        start_op(32'h8000_0000, 32'h0000_0001, 1'b1); wait_done(n); lit("sovf_sub",   32'h7FFF_FFFF, 1, 1, n);

        // Start during RUN is ignored.
        start_op(32'h0000_1000, 32'h0000_0234, 1'b0);
        @(negedge clk);
        start_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        wait_done(n);
        lit("ignore", 32'h0000_1234, 0, 0, n + 2);

        // Back-to-back start in the DONE cycle.
        start_op(32'h0000_0010, 32'h0000_0020, 1'b0);
        wait_done(n);
        lit("b2b_1", 32'h0000_0030, 0, 0, n);
        start_op(32'h0000_0100, 32'h0000_0001, 1'b1);
        wait_done(n);
        lit("b2b_2", 32'h0000_00FF, 1, 0, n);

        // Reset in the second RUN cycle aborts.
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_sum",  64'(sum),  64'd0);
        repeat (6) @(negedge clk);
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0); wait_done(n); lit("fresh", 32'h2345_6789, 0, 0, n);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 60; i++) begin
            start_op(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; a = $urandom(); b = $urandom(); sub = 1'($urandom_range(0, 1));
                @(negedge clk);
                start = 1'b0;
            end
            wait_done(n);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
